// File: rtl/hpu_pkg.sv
// Shared definitions for the HPU control/status register block: AXI-Lite widths,
// register offsets, FSM encoding, response codes and small decode helpers.
package hpu_pkg;

  localparam int unsigned AXI_AW = 12;
  localparam int unsigned AXI_DW = 32;
  localparam int unsigned AXI_SW = 4;

  localparam logic [AXI_AW-1:0] OFF_CTRL       = 12'h000;
  localparam logic [AXI_AW-1:0] OFF_STATUS     = 12'h004;
  localparam logic [AXI_AW-1:0] OFF_ADDR_I     = 12'h008;
  localparam logic [AXI_AW-1:0] OFF_ADDR_J     = 12'h00C;
  localparam logic [AXI_AW-1:0] OFF_SCRATCH    = 12'h010;
  localparam logic [AXI_AW-1:0] OFF_RANDOM_NUM = 12'h014;
  localparam logic [AXI_AW-1:0] OFF_CYCLES     = 12'h018;
  localparam logic [AXI_AW-1:0] OFF_CORE_EN    = 12'h01C;
  localparam logic [AXI_AW-1:0] OFF_IRQ_EN     = 12'h020;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_AW   = 3'd1,
    ST_W    = 3'd2,
    ST_AWW  = 3'd3,
    ST_AR1  = 3'd4,
    ST_AR2  = 3'd5
  } axil_state_e;

  typedef struct packed {
    logic [AXI_AW-1:0] addr;
    logic [AXI_DW-1:0] data;
    logic [AXI_SW-1:0] strb;
  } axil_wr_t;

  // Byte-lane merge of new data over an old word under a write strobe
  function automatic logic [AXI_DW-1:0] strb_merge(input logic [AXI_DW-1:0] old_v,
                                                    input logic [AXI_DW-1:0] new_v,
                                                    input logic [AXI_SW-1:0] strb);
    logic [AXI_DW-1:0] r;
    r = old_v;
    for (int b = 0; b < int'(AXI_SW); b++) begin
      if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic addr_mapped(input logic [AXI_AW-1:0] a);
    return a inside {OFF_CTRL, OFF_STATUS, OFF_ADDR_I, OFF_ADDR_J, OFF_SCRATCH,
                     OFF_RANDOM_NUM, OFF_CYCLES, OFF_CORE_EN, OFF_IRQ_EN};
  endfunction

  function automatic logic wr_addr_err(input logic [AXI_AW-1:0] a);
    return !addr_mapped(a) || (a == OFF_CYCLES);
  endfunction

endpackage

// File: rtl/hpu_csr_if.sv
// AXI4-Lite register port bundle (32-bit data, 12-bit address).
interface hpu_csr_if;
  import hpu_pkg::*;

  logic [AXI_AW-1:0] awaddr;
  logic              awvalid;
  logic              awready;
  logic [AXI_DW-1:0] wdata;
  logic [AXI_SW-1:0] wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [AXI_AW-1:0] araddr;
  logic              arvalid;
  logic              arready;
  logic [AXI_DW-1:0] rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

endinterface

// File: rtl/hpu_axil_slave.sv
// AXI4-Lite slave FSM: collects AW/W in either order, issues a single-cycle
// register write strobe, and performs two-cycle register reads.
module hpu_axil_slave
  import hpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  hpu_csr_if.slave          s_axi,
  output logic              wr_en,
  output logic [AXI_AW-1:0] wr_addr,
  output logic [AXI_DW-1:0] wr_data,
  output logic [AXI_SW-1:0] wr_strb,
  output logic              rd_en,
  output logic [AXI_AW-1:0] rd_addr,
  input  logic [AXI_DW-1:0] rd_data,
  input  logic              rd_err
);

  axil_state_e       state_q, state_d;
  axil_wr_t          wreq_q, wreq_d;
  logic [AXI_AW-1:0] rd_addr_q, rd_addr_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              wr_en_q, wr_en_d;
  logic              rd_en_q, rd_en_d;
  logic              awready_q, wready_q, arready_q, bvalid_q, rvalid_q;
  logic [AXI_DW-1:0] rdata_q;
  logic [1:0]        rresp_q;

  // Next-state and capture of the pending write / read address
  always_comb begin
    state_d   = state_q;
    wreq_d    = wreq_q;
    rd_addr_d = rd_addr_q;
    bresp_d   = bresp_q;
    wr_en_d   = 1'b0;
    rd_en_d   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (s_axi.awvalid && s_axi.wvalid) begin
          wreq_d  = '{addr: s_axi.awaddr, data: s_axi.wdata, strb: s_axi.wstrb};
          state_d = ST_AWW;
        end else if (s_axi.awvalid) begin
          wreq_d.addr = s_axi.awaddr;
          state_d     = ST_AW;
        end else if (s_axi.wvalid) begin
          wreq_d.data = s_axi.wdata;
          wreq_d.strb = s_axi.wstrb;
          state_d     = ST_W;
        end else if (s_axi.arvalid) begin
          rd_addr_d = s_axi.araddr;
          state_d   = ST_AR1;
        end
      end
      ST_AW: begin
        if (s_axi.wvalid) begin
          wreq_d.data = s_axi.wdata;
          wreq_d.strb = s_axi.wstrb;
          state_d     = ST_AWW;
        end
      end
      ST_W: begin
        if (s_axi.awvalid) begin
          wreq_d.addr = s_axi.awaddr;
          state_d     = ST_AWW;
        end
      end
      ST_AWW: if (s_axi.bready) state_d = ST_IDLE;
      ST_AR1: state_d = ST_AR2;
      ST_AR2: if (s_axi.rready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Exactly one commit strobe, in the first cycle of AWW
    wr_en_d = (state_d == ST_AWW) && (state_q != ST_AWW);
    if (wr_en_d) bresp_d = wr_addr_err(wreq_d.addr) ? RESP_SLVERR : RESP_OKAY;
    rd_en_d = (state_d == ST_AR1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wreq_q    <= '0;
      rd_addr_q <= '0;
      bresp_q   <= RESP_OKAY;
      wr_en_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      awready_q <= 1'b1;
      wready_q  <= 1'b1;
      arready_q <= 1'b1;
      bvalid_q  <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      state_q   <= state_d;
      wreq_q    <= wreq_d;
      rd_addr_q <= rd_addr_d;
      bresp_q   <= bresp_d;
      wr_en_q   <= wr_en_d;
      rd_en_q   <= rd_en_d;
      awready_q <= (state_d == ST_IDLE) || (state_d == ST_W);
      wready_q  <= (state_d == ST_IDLE) || (state_d == ST_AW);
      arready_q <= (state_d == ST_IDLE);
      bvalid_q  <= (state_d == ST_AWW);
      rvalid_q  <= (state_d == ST_AR2);
      if (state_q == ST_AR1) begin
        rdata_q <= rd_data;
        rresp_q <= rd_err ? RESP_SLVERR : RESP_OKAY;
      end
    end
  end

  assign s_axi.awready = awready_q;
  assign s_axi.wready  = wready_q;
  assign s_axi.arready = arready_q;
  assign s_axi.bvalid  = bvalid_q;
  assign s_axi.bresp   = bresp_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = rdata_q;
  assign s_axi.rresp   = rresp_q;

  assign wr_en   = wr_en_q;
  assign wr_addr = wreq_q.addr;
  assign wr_data = wreq_q.data;
  assign wr_strb = wreq_q.strb;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;

endmodule

// File: rtl/hpu_csr.sv
// HPU control/status registers: run/gen mode control, loop bounds, item count,
// core enables, run cycle counter and level interrupt behind an AXI-Lite port.
module hpu_csr
  import hpu_pkg::*;
#(
  parameter int unsigned NUM_CORES = 1,
  parameter int unsigned ITEM_W    = 16,
  parameter int unsigned IDX_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  hpu_csr_if.slave             s_axi,
  input  logic [ITEM_W-1:0]    item_cnt,
  input  logic                 done_pulse,
  output logic                 run,
  output logic                 gen,
  output logic [IDX_W-1:0]     addr_i,
  output logic [IDX_W-1:0]     addr_j,
  output logic [ITEM_W-1:0]    random_num,
  output logic [NUM_CORES-1:0] core_en,
  output logic                 irq
);

  localparam logic [AXI_DW-1:0] CYC_MAX = '1;

  logic              wr_en, rd_en;
  logic [AXI_AW-1:0] wr_addr, rd_addr;
  logic [AXI_DW-1:0] wr_data;
  logic [AXI_SW-1:0] wr_strb;
  logic [AXI_DW-1:0] rd_data_c;
  logic              rd_err_c;

  hpu_axil_slave u_axil (
    .clk     (clk),
    .rst     (rst),
    .s_axi   (s_axi),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .wr_strb (wr_strb),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (rd_data_c),
    .rd_err  (rd_err_c)
  );

  logic                 gen_q, gen_d, run_q, run_d, auto_stop_q, auto_stop_d;
  logic                 gen_done_q, gen_done_d, run_done_q, run_done_d;
  logic [IDX_W-1:0]     addr_i_q, addr_i_d, addr_j_q, addr_j_d;
  logic [AXI_DW-1:0]    scratch_q, scratch_d, cycles_q, cycles_d;
  logic [ITEM_W-1:0]    random_num_q, random_num_d;
  logic [NUM_CORES-1:0] core_en_q, core_en_d;
  logic [1:0]           irq_en_q, irq_en_d;
  logic                 irq_q, irq_d;
  logic [2:0]           ctrl_w;
  logic [1:0]           status_w1c;
  logic                 gen_hit;

  // Register updates: bus write plus datapath events; events win over W1C
  always_comb begin
    gen_d        = gen_q;
    run_d        = run_q;
    auto_stop_d  = auto_stop_q;
    gen_done_d   = gen_done_q;
    run_done_d   = run_done_q;
    addr_i_d     = addr_i_q;
    addr_j_d     = addr_j_q;
    scratch_d    = scratch_q;
    random_num_d = random_num_q;
    core_en_d    = core_en_q;
    irq_en_d     = irq_en_q;
    cycles_d     = cycles_q;

    ctrl_w     = 3'(strb_merge(32'({auto_stop_q, run_q, gen_q}), wr_data, wr_strb));
    status_w1c = 2'(strb_merge(32'h0, wr_data, wr_strb));
    gen_hit    = gen_q && (item_cnt == random_num_q);

    if (gen_hit) gen_d = 1'b0;
    if (done_pulse && auto_stop_q) run_d = 1'b0;

    if (wr_en) begin
      case (wr_addr)
        OFF_CTRL: begin
          gen_d       = ctrl_w[0];
          run_d       = ctrl_w[1];
          auto_stop_d = ctrl_w[2];
        end
        OFF_STATUS: begin
          gen_done_d = gen_done_q & ~status_w1c[0];
          run_done_d = run_done_q & ~status_w1c[1];
        end
        OFF_ADDR_I:     addr_i_d     = IDX_W'(strb_merge(32'(addr_i_q), wr_data, wr_strb));
        OFF_ADDR_J:     addr_j_d     = IDX_W'(strb_merge(32'(addr_j_q), wr_data, wr_strb));
        OFF_SCRATCH:    scratch_d    = strb_merge(scratch_q, wr_data, wr_strb);
        OFF_RANDOM_NUM: random_num_d = ITEM_W'(strb_merge(32'(random_num_q), wr_data, wr_strb));
        OFF_CORE_EN:    core_en_d    = NUM_CORES'(strb_merge(32'(core_en_q), wr_data, wr_strb));
        OFF_IRQ_EN:     irq_en_d     = 2'(strb_merge(32'(irq_en_q), wr_data, wr_strb));
        default: ;
      endcase
    end

    if (gen_hit)    gen_done_d = 1'b1;
    if (done_pulse) run_done_d = 1'b1;

    if (run_d && !run_q)                      cycles_d = '0;
    else if (run_q && (cycles_q != CYC_MAX)) cycles_d = cycles_q + 32'd1;

    irq_d = |({run_done_q, gen_done_q} & irq_en_q);
  end

  // Read mux, sampled by the slave in its first read cycle
  always_comb begin
    rd_data_c = '0;
    rd_err_c  = 1'b0;
    case (rd_addr)
      OFF_CTRL:       rd_data_c = 32'({auto_stop_q, run_q, gen_q});
      OFF_STATUS:     rd_data_c = 32'({run_done_q, gen_done_q});
      OFF_ADDR_I:     rd_data_c = 32'(addr_i_q);
      OFF_ADDR_J:     rd_data_c = 32'(addr_j_q);
      OFF_SCRATCH:    rd_data_c = scratch_q;
      OFF_RANDOM_NUM: rd_data_c = 32'(random_num_q);
      OFF_CYCLES:     rd_data_c = cycles_q;
      OFF_CORE_EN:    rd_data_c = 32'(core_en_q);
      OFF_IRQ_EN:     rd_data_c = 32'(irq_en_q);
      default:        rd_err_c  = 1'b1;
    endcase
    if (!rd_en) rd_data_c = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gen_q        <= 1'b0;
      run_q        <= 1'b0;
      auto_stop_q  <= 1'b0;
      gen_done_q   <= 1'b0;
      run_done_q   <= 1'b0;
      addr_i_q     <= IDX_W'(299);
      addr_j_q     <= IDX_W'(2);
      scratch_q    <= '0;
      random_num_q <= ITEM_W'(1000);
      core_en_q    <= '1;
      irq_en_q     <= '0;
      cycles_q     <= '0;
      irq_q        <= 1'b0;
    end else begin
      gen_q        <= gen_d;
      run_q        <= run_d;
      auto_stop_q  <= auto_stop_d;
      gen_done_q   <= gen_done_d;
      run_done_q   <= run_done_d;
      addr_i_q     <= addr_i_d;
      addr_j_q     <= addr_j_d;
      scratch_q    <= scratch_d;
      random_num_q <= random_num_d;
      core_en_q    <= core_en_d;
      irq_en_q     <= irq_en_d;
      cycles_q     <= cycles_d;
      irq_q        <= irq_d;
    end
  end

  assign run        = run_q;
  assign gen        = gen_q;
  assign addr_i     = addr_i_q;
  assign addr_j     = addr_j_q;
  assign random_num = random_num_q;
  assign core_en    = core_en_q;
  assign irq        = irq_q;

endmodule
